// File: rtl/pwm_stream_modulator.sv
// Streaming PWM modulator: one amplitude sample per PWM symbol,
// one-deep hold buffer, left/centre alignment and underrun tracking.
module pwm_stream_modulator #(
  parameter int CLKS_PER_STEP = 2,
  parameter int PWM_STEPS     = 64,
  parameter int WIDTH         = $clog2(PWM_STEPS + 1),
  parameter bit CENTER        = 1'b0,
  parameter bit UNDERRUN_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm,
  output logic             symb_tick,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam int PW = (CLKS_PER_STEP > 1) ?
                      $clog2(CLKS_PER_STEP) : 1;
  localparam int SW = $clog2(PWM_STEPS);
  localparam int DW = $clog2(PWM_STEPS + 1);

  localparam logic [PW-1:0] PRE_TC   = PW'(CLKS_PER_STEP - 1);
  localparam logic [SW-1:0] STEP_TC  = SW'(PWM_STEPS - 1);
  localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_STEPS);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_n;
  logic [SW-1:0]    step;
  logic [SW-1:0]    step_n;
  logic             running;
  logic             running_n;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [DW-1:0]    active_duty;
  logic [DW-1:0]    duty_n;
  logic [DW-1:0]    hold_sat;
  logic [31:0]      hold_w;
  logic             step_tc;
  logic             bnd;
  logic             xfer;
  logic             level_n;

  function automatic logic level(
    input logic [SW-1:0] s,
    input logic [DW-1:0] d
  );
    int unsigned si;
    int unsigned di;
    int unsigned off;
    si  = 32'(s);
    di  = 32'(d);
    off = (32'(PWM_STEPS) - di) >> 1;
    if (CENTER)
      return (si >= off) && (si < off + di);
    else
      return si < di;
  endfunction

  assign hold_w   = 32'(hold);
  assign hold_sat = (hold_w >= 32'(PWM_STEPS)) ?
                    DUTY_MAX : DW'(hold_w);

  assign step_tc = running & (pre == PRE_TC);
  assign bnd     = enable &
                   (~running | (step_tc & (step == STEP_TC)));
  assign xfer    = sample_valid & ~hold_full;

  assign sample_ready = ~hold_full;

  // pwm is registered from next-state counters so that step 0
  // of a new symbol appears together with symb_tick.
  always_comb begin
    pre_n     = pre;
    step_n    = step;
    running_n = running;
    duty_n    = active_duty;
    if (!enable) begin
      pre_n     = '0;
      step_n    = '0;
      running_n = 1'b0;
    end else if (bnd) begin
      pre_n     = '0;
      step_n    = '0;
      running_n = 1'b1;
      if (hold_full)
        duty_n = hold_sat;
      else if (!UNDERRUN_HOLD)
        duty_n = '0;
    end else if (step_tc) begin
      pre_n  = '0;
      step_n = step + 1'b1;
    end else begin
      pre_n = pre + 1'b1;
    end
    level_n = running_n & level(step_n, duty_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre          <= '0;
      step         <= '0;
      running      <= 1'b0;
      hold         <= '0;
      hold_full    <= 1'b0;
      active_duty  <= '0;
      pwm          <= 1'b0;
      symb_tick    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      pre         <= pre_n;
      step        <= step_n;
      running     <= running_n;
      active_duty <= duty_n;
      pwm         <= level_n;
      symb_tick   <= bnd;
      underrun    <= bnd & ~hold_full;
      if (bnd & ~hold_full & (underrun_cnt != 8'hff))
        underrun_cnt <= underrun_cnt + 8'd1;
      if (bnd & hold_full) begin
        hold_full <= 1'b0;
      end else if (xfer) begin
        hold      <= sample_data;
        hold_full <= 1'b1;
      end
    end
  end

endmodule
